experiment_controller: RTL and testbench

EXPERIMENT_CONTROLLER -- requirements
Module: experiment_controller

---
 rtl/experiment_controller.sv | 89 ++++++++
 tb/tb_experiment_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/experiment_controller.sv
// experiment_controller: sequences network init, stimulus presentation, replay and run bookkeeping
module experiment_controller #(
   parameter int          NUM_TRIALS     = 100,
   parameter int          NUM_RUNS       = 10,
   parameter int          INIT_CYCLES    = 3,
   parameter int          REPLAY_TIMEOUT = 2048,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       change_InVec,
   input  logic       brk,
   input  logic       rewarded,
   input  logic       finish_replay_phase,
   output logic       net_reset,
   output logic       reset_lfsr_weight,
   output logic       run,
   output logic       active,
   output logic [5:0] InVec,
   output logic [9:0] iTrial,
   output logic [9:0] iRun,
   output logic       ctrl_iRun,
   output logic       write_percorrect,
   output logic [9:0] n_correct,
   output logic       the_end_of_the_experiment,
   output logic       timeout_err
);
   localparam int CW = $clog2(REPLAY_TIMEOUT > INIT_CYCLES ? REPLAY_TIMEOUT : INIT_CYCLES) + 1;
   typedef enum logic [2:0] {IDLE, INIT, PRESENT, REPLAY, NEXT, RUN_END, DONE} state_t;
   state_t        state, nxt;
   logic [CW-1:0] cnt;
   logic [15:0]   lfsr;
   logic          brk_q, brk_edge, load, replay_expired;
   logic [5:0]    stim;
   assign brk_edge       = brk && !brk_q;
   assign replay_expired = cnt == CW'(REPLAY_TIMEOUT - 1);
   assign stim           = {lfsr[2] ? 2'b10 : 2'b01, 4'b0001 << lfsr[1:0]};
   // a brk edge leaves PRESENT, so it always beats change_InVec
   assign load           = (nxt == PRESENT) && (state != PRESENT || change_InVec);
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         lfsr        <= LFSR_SEED;
         brk_q       <= 1'b0;
         InVec       <= '0;
         iTrial      <= '0;
         iRun        <= '0;
         n_correct   <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= nxt;
         cnt   <= (nxt != state) ? '0 : cnt + 1'b1;
         lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         brk_q <= brk;
         if (load) InVec <= stim;
         if (state == PRESENT && brk_edge && rewarded) n_correct <= n_correct + 1'b1;
         if (state == REPLAY && !finish_replay_phase && replay_expired) timeout_err <= 1'b1;
         if (state == NEXT && nxt == PRESENT) iTrial <= iTrial + 1'b1;
         if (state == RUN_END) begin
            iRun      <= iRun + 1'b1;
            iTrial    <= '0;
            n_correct <= '0;
         end
      end
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? INIT : IDLE;
         INIT:    nxt = (cnt == CW'(INIT_CYCLES - 1)) ? PRESENT : INIT;
         PRESENT: nxt = brk_edge ? REPLAY : PRESENT;
         REPLAY:  nxt = (finish_replay_phase || replay_expired) ? NEXT : REPLAY;
         NEXT:    nxt = (iTrial == 10'(NUM_TRIALS - 1)) ? RUN_END : PRESENT;
         RUN_END: nxt = (iRun == 10'(NUM_RUNS - 1)) ? DONE : INIT;
         default: nxt = state;
      endcase
   end
   always_comb begin
      run                       = state == PRESENT || state == REPLAY || state == NEXT;
      active                    = run;
      net_reset                 = state == IDLE || state == INIT;
      reset_lfsr_weight         = state == INIT && iRun == '0;
      write_percorrect          = state == RUN_END;
      ctrl_iRun                 = state == RUN_END;
      the_end_of_the_experiment = state == DONE;
   end
endmodule

// File: tb/tb_experiment_controller.sv
// tb_experiment_controller: directed stimulus with a run-end scoreboard and a stimulus-load monitor
module tb_experiment_controller;
   logic       clk = 1'b0;
   logic       reset, start, change_InVec, brk, rewarded, finish_replay_phase;
   logic       net_reset, reset_lfsr_weight, run, active, ctrl_iRun, write_percorrect;
   logic       the_end_of_the_experiment, timeout_err;
   logic [5:0] InVec;
   logic [9:0] iTrial, iRun, n_correct;

   experiment_controller #(
      .NUM_TRIALS(3), .NUM_RUNS(2), .INIT_CYCLES(3), .REPLAY_TIMEOUT(8), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .change_InVec(change_InVec), .brk(brk),
      .rewarded(rewarded), .finish_replay_phase(finish_replay_phase), .net_reset(net_reset),
      .reset_lfsr_weight(reset_lfsr_weight), .run(run), .active(active), .InVec(InVec),
      .iTrial(iTrial), .iRun(iRun), .ctrl_iRun(ctrl_iRun), .write_percorrect(write_percorrect),
      .n_correct(n_correct), .the_end_of_the_experiment(the_end_of_the_experiment),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {int nc; int ir; int it;} exp_t;
   exp_t        sb[$];
   exp_t        x;
   int          passed = 0, total = 0;
   logic [15:0] m_lfsr;
   logic [5:0]  inv;
   logic [43:0] snap;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   function automatic logic [43:0] outs();
      return {net_reset, reset_lfsr_weight, run, active, InVec, iTrial, iRun, write_percorrect,
              ctrl_iRun, n_correct, the_end_of_the_experiment, timeout_err};
   endfunction

   // reference stimulus LFSR: 16-bit Fibonacci, taps 16,14,13,11
   always @(posedge clk)
      m_lfsr <= reset ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

   // every new stimulus must be the cue/context mapping of the LFSR value before the edge
   initial begin
      logic [15:0] pre;
      logic        r;
      logic [5:0]  last, e;
      last = '0;
      forever begin
         @(posedge clk);
         pre = m_lfsr;
         r   = reset;
         #1;
         if (!r && InVec !== last) begin
            e = {pre[2] ? 2'b10 : 2'b01, 4'b0001 << pre[1:0]};
            chk("invec_load", InVec, e);
         end
         last = InVec;
      end
   end

   // run-end strobe monitor
   always @(negedge clk)
      if (write_percorrect || ctrl_iRun) begin
         if (sb.size() == 0) chk("strobe_expected", sb.size(), 1);
         else begin
            x = sb.pop_front();
            chk("wpc_n_correct", n_correct, x.nc);
            chk("wpc_iRun", iRun, x.ir);
            chk("wpc_iTrial", iTrial, x.it);
            chk("wpc_ctrl_pair", {ctrl_iRun, write_percorrect}, 2'b11);
         end
      end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks", passed, total);
      $fatal(1);
   end

   task automatic trial(input logic rew);
      brk = 1; rewarded = rew; @(negedge clk);
      brk = 0; rewarded = 0; finish_replay_phase = 1; @(negedge clk);
      finish_replay_phase = 0; @(negedge clk);
   endtask

   task automatic wait_present();
      int n = 0;
      while (!run && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("present_reached", run, 1);
   endtask

   initial begin
      reset = 1; start = 0; change_InVec = 0; brk = 0; rewarded = 0; finish_replay_phase = 0;
      @(negedge clk); @(negedge clk);
      reset = 0;
      chk("rst_net_reset", net_reset, 1);
      chk("rst_flags", {reset_lfsr_weight, run, active, write_percorrect, ctrl_iRun,
                        the_end_of_the_experiment, timeout_err}, 0);
      chk("rst_invec", InVec, 0);
      chk("rst_counters", {iTrial, iRun, n_correct}, 0);
      start = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 0;
         chk("init_net_reset", net_reset, 1);
         chk("init_weight", reset_lfsr_weight, 1);
         chk("init_run", run, 0);
      end
      @(negedge clk);
      chk("present_run_active_nr", {run, active, net_reset}, 3'b110);
      chk("cue_onehot", $countones(InVec[3:0]), 1);
      chk("ctx_onehot", $countones(InVec[5:4]), 1);
      trial(1);
      chk("nc_t1", n_correct, 1);
      chk("itrial_t1", iTrial, 1);
      trial(0);
      chk("nc_t2", n_correct, 1);
      chk("itrial_t2", iTrial, 2);
      sb.push_back('{2, 0, 2});
      trial(1);
      @(negedge clk);
      chk("run2_iRun", iRun, 1);
      chk("run2_clear", {iTrial, n_correct}, 0);
      chk("run2_net_reset", net_reset, 1);
      chk("run2_weight", reset_lfsr_weight, 0);
      wait_present();
      // replay timeout with finish withheld
      brk = 1; rewarded = 0; @(negedge clk);
      brk = 0;
      repeat (7) @(negedge clk);
      chk("to_before", timeout_err, 0);
      chk("to_replay_run", run, 1);
      @(negedge clk);
      chk("to_set", timeout_err, 1);
      chk("to_itrial_next", iTrial, 0);
      @(negedge clk);
      chk("to_itrial_inc", iTrial, 1);
      chk("to_present", run, 1);
      // brk edge together with change_InVec
      inv = InVec; brk = 1; change_InVec = 1; rewarded = 1; @(negedge clk);
      change_InVec = 0; rewarded = 0;
      chk("brk_wins_invec", InVec, inv);
      chk("brk_wins_nc", n_correct, 1);
      finish_replay_phase = 1; @(negedge clk);
      finish_replay_phase = 0; @(negedge clk);
      chk("held_itrial", iTrial, 2);
      change_InVec = 1; @(negedge clk);
      change_InVec = 0;
      chk("chg_run", run, 1);
      repeat (2) @(negedge clk);
      finish_replay_phase = 1; @(negedge clk);
      finish_replay_phase = 0;
      repeat (2) @(negedge clk);
      chk("held_brk_itrial", iTrial, 2);
      chk("held_brk_irun", iRun, 1);
      chk("held_brk_nc", n_correct, 1);
      brk = 0; @(negedge clk);
      sb.push_back('{1, 1, 2});
      trial(0);
      @(negedge clk);
      chk("done_end", the_end_of_the_experiment, 1);
      chk("done_irun", iRun, 2);
      chk("done_clear", {iTrial, n_correct}, 0);
      chk("done_quiet", {run, active, net_reset}, 0);
      chk("done_timeout", timeout_err, 1);
      snap = outs();
      start = 1; change_InVec = 1; rewarded = 1; finish_replay_phase = 1;
      for (int i = 0; i < 4; i++) begin
         brk = ~brk;
         @(negedge clk);
      end
      start = 0; change_InVec = 0; rewarded = 0; finish_replay_phase = 0; brk = 0;
      chk("done_hold", outs(), snap);
      // reset during REPLAY of trial 2
      reset = 1; @(negedge clk);
      reset = 0;
      chk("rst2_timeout_clr", timeout_err, 0);
      start = 1; @(negedge clk);
      start = 0;
      wait_present();
      trial(1);
      brk = 1; @(negedge clk);
      brk = 0; reset = 1; @(negedge clk);
      reset = 0;
      chk("abort_net_reset", net_reset, 1);
      chk("abort_flags", {reset_lfsr_weight, run, active, write_percorrect, ctrl_iRun,
                          the_end_of_the_experiment, timeout_err}, 0);
      chk("abort_counters", {iTrial, iRun, n_correct}, 0);
      chk("abort_invec", InVec, 0);
      @(negedge clk);
      chk("abort_idle", {net_reset, run, write_percorrect}, 3'b100);
      start = 1; @(negedge clk);
      start = 0;
      wait_present();
      chk("restart_cue_onehot", $countones(InVec[3:0]), 1);
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
